dram_bus_target: RTL and testbench

- Synchronous responder on the Brew V1 external DRAM-style bus: the far end of the nRAS/nCAS_a/nCAS_b/nWE/nWAIT interface the core drives.
- Decodes row/column multiplexed cycles and serves reads/writes from an internal 16-bit-wide, byte-laned memory.
- Inserts programmable wait states via nWAIT.
- Used as simulation memory model and as an on-board SRAM/peripheral target in FPGA builds; shares clk with the core.

---
 rtl/brew_bus_pkg.sv | 20 ++
 rtl/dram_bus_target_mem.sv | 44 ++++
 rtl/dram_bus_target.sv | 243 ++++++++++++++++++++++++
 tb/tb_dram_bus_target.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/brew_bus_pkg.sv
// Purpose: shared types and constants for the Brew V1 external DRAM-style bus.
// Latency: n/a (declarations only).
// Backpressure: n/a; the bus itself stalls the initiator through nWAIT.
package brew_bus_pkg;

  localparam int DRAM_ADDR_W = 11;
  localparam int DRAM_DATA_W = 8;

  // Byte lane selected by the CAS strobe that opened the access.
  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ROW_OPEN,
    WAIT,
    ACCESS
  } bus_state_e;

endpackage

// File: rtl/dram_bus_target_mem.sv
// Purpose: byte-laned backing store, two 8-bit arrays sharing one word index.
// Latency: read data registered, valid the cycle after rd_en; writes land on the edge.
// Backpressure: none; accepts a write or a read every cycle.
//
// Ports: clk/rst, we_a/we_b per-lane write enables, addr word index,
//        wr_dat write byte, rd_en/rd_lane read request, rd_dat registered read byte.
module dram_bus_target_mem
  import brew_bus_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_a,
  input  logic                   we_b,
  input  logic [AW-1:0]          addr,
  input  logic [DRAM_DATA_W-1:0] wr_dat,
  input  logic                   rd_en,
  input  logic                   rd_lane,
  output logic [DRAM_DATA_W-1:0] rd_dat
);

  localparam int DEPTH = 1 << AW;

  logic [DRAM_DATA_W-1:0] mem_a [0:DEPTH-1];
  logic [DRAM_DATA_W-1:0] mem_b [0:DEPTH-1];

  // Contents survive reset, but a write racing a reset is dropped.
  always_ff @(posedge clk) begin
    if (we_a && !rst) mem_a[addr] <= wr_dat;
    if (we_b && !rst) mem_b[addr] <= wr_dat;
  end

  // Read register only loads on request so the returned byte is held for
  // the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= (rd_lane == LANE_B) ? mem_b[addr] : mem_a[addr];
    end
  end

endmodule

// File: rtl/dram_bus_target.sv
// Purpose: responder for the nRAS/nCAS_a/nCAS_b/nWE bus, serving a byte-laned memory.
// Latency: inputs registered, decode 1 cycle later; read data valid WAIT_STATES+1 cycles after decoded CAS fall.
// Backpressure: holds dram_nWAIT low for WAIT_STATES cycles per CAS access.
//
// Ports: clk, rst (sync, active-high); dram_nRAS, dram_nCAS_a, dram_nCAS_b, dram_addr,
//        dram_nWE, dram_data_in from the initiator; dram_data_out/dram_data_oe read
//        drive, dram_nWAIT stall, proto_err one-cycle protocol violation pulse.
module dram_bus_target
  import brew_bus_pkg::*;
#(
  parameter int ROW_AW      = 4,
  parameter int COL_AW      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dram_nRAS,
  input  logic                   dram_nCAS_a,
  input  logic                   dram_nCAS_b,
  input  logic [DRAM_ADDR_W-1:0] dram_addr,
  input  logic                   dram_nWE,
  input  logic [DRAM_DATA_W-1:0] dram_data_in,
  output logic [DRAM_DATA_W-1:0] dram_data_out,
  output logic                   dram_data_oe,
  output logic                   dram_nWAIT,
  output logic                   proto_err
);

  localparam int AW  = ROW_AW + COL_AW;
  localparam int SAW = (ROW_AW > COL_AW) ? ROW_AW : COL_AW;
  localparam int CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  // Registered bus copies and their previous values for edge detection.
  logic                   s_nras, s_ncas_a, s_ncas_b, s_nwe;
  logic [DRAM_ADDR_W-1:0] s_addr;
  logic [DRAM_DATA_W-1:0] s_data_in;
  logic                   p_nras, p_ncas_a, p_ncas_b, p_nwe;

  bus_state_e state, state_nxt;

  logic [ROW_AW-1:0] row_q;
  logic [COL_AW-1:0] col_q;
  logic              lane_q, nwe_q, first_q;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic              oe_q, oe_nxt, nwait_q, nwait_nxt, proto_q, proto_nxt, first_nxt;
  logic              ld_row, ld_col;

  logic          mem_we_a, mem_we_b, mem_rd_en, mem_rd_lane;
  logic [AW-1:0] mem_addr;

  // Upper address bits alias onto the implemented array.
  generate
    if (SAW < DRAM_ADDR_W) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^s_addr[DRAM_ADDR_W-1:SAW];
    end
  endgenerate

  logic ras_fall, ras_rise, cas_a_fall, cas_b_fall, nwe_chg;
  logic other_fall, lane_released, wait_done, lane_now;

  assign ras_fall   = p_nras & ~s_nras;
  assign ras_rise   = ~p_nras & s_nras;
  assign cas_a_fall = p_ncas_a & ~s_ncas_a;
  assign cas_b_fall = p_ncas_b & ~s_ncas_b;
  assign nwe_chg    = p_nwe ^ s_nwe;
  assign lane_now   = cas_b_fall ? LANE_B : LANE_A;

  // Strobe of the lane not owning the current access.
  assign other_fall = (lane_q == LANE_B) ? cas_a_fall : cas_b_fall;

  // Level check: ends the access even if the owning CAS already rose during WAIT.
  assign lane_released = (lane_q == LANE_B) ? s_ncas_b : s_ncas_a;

  // Counter about to reach zero on this edge.
  assign wait_done = (cnt_q == CW'(1));

  // While decoding a CAS fall the column comes straight off the bus, so a
  // zero-wait read can be issued on the same edge.
  assign mem_addr    = ld_col ? {row_q, s_addr[COL_AW-1:0]} : {row_q, col_q};
  assign mem_rd_lane = ld_col ? lane_now : lane_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; nRAS rise has priority over everything once a row is open.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ras_fall) state_nxt = ROW_OPEN;
      end
      ROW_OPEN: begin
        if (ras_rise) state_nxt = IDLE;
        else if (cas_a_fall ^ cas_b_fall)
          state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        if (ras_rise)       state_nxt = IDLE;
        else if (wait_done) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (ras_rise)           state_nxt = IDLE;
        else if (lane_released) state_nxt = ROW_OPEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    oe_nxt    = oe_q;
    nwait_nxt = 1'b1;
    proto_nxt = 1'b0;
    cnt_nxt   = cnt_q;
    first_nxt = 1'b0;
    ld_row    = 1'b0;
    ld_col    = 1'b0;
    mem_we_a  = 1'b0;
    mem_we_b  = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        oe_nxt    = 1'b0;
        ld_row    = ras_fall;
        proto_nxt = cas_a_fall | cas_b_fall;
      end
      ROW_OPEN: begin
        oe_nxt = 1'b0;
        if (!ras_rise) begin
          if (cas_a_fall && cas_b_fall) begin
            proto_nxt = 1'b1;
          end else if (cas_a_fall || cas_b_fall) begin
            ld_col = 1'b1;
            if (WAIT_STATES > 0) begin
              cnt_nxt   = CW'(WAIT_STATES);
              nwait_nxt = 1'b0;
            end else begin
              first_nxt = 1'b1;
              mem_rd_en = s_nwe;
              oe_nxt    = s_nwe;
            end
          end
        end
      end
      WAIT: begin
        if (ras_rise) begin
          proto_nxt = 1'b1;
          oe_nxt    = 1'b0;
        end else begin
          proto_nxt = other_fall | nwe_chg;
          cnt_nxt   = cnt_q - CW'(1);
          if (wait_done) begin
            first_nxt = 1'b1;
            mem_rd_en = nwe_q;
            oe_nxt    = nwe_q;
          end else begin
            nwait_nxt = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (ras_rise) begin
          // Abort in the first ACCESS cycle drops the pending write.
          proto_nxt = 1'b1;
          oe_nxt    = 1'b0;
        end else begin
          proto_nxt = other_fall | nwe_chg;
          mem_we_a  = first_q & ~nwe_q & (lane_q == LANE_A);
          mem_we_b  = first_q & ~nwe_q & (lane_q == LANE_B);
          if (lane_released) oe_nxt = 1'b0;
        end
      end
      default: oe_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_nras    <= 1'b1;
      s_ncas_a  <= 1'b1;
      s_ncas_b  <= 1'b1;
      s_nwe     <= 1'b1;
      s_addr    <= '0;
      s_data_in <= '0;
      p_nras    <= 1'b1;
      p_ncas_a  <= 1'b1;
      p_ncas_b  <= 1'b1;
      p_nwe     <= 1'b1;
      row_q     <= '0;
      col_q     <= '0;
      lane_q    <= LANE_A;
      nwe_q     <= 1'b1;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      oe_q      <= 1'b0;
      nwait_q   <= 1'b1;
      proto_q   <= 1'b0;
    end else begin
      s_nras    <= dram_nRAS;
      s_ncas_a  <= dram_nCAS_a;
      s_ncas_b  <= dram_nCAS_b;
      s_nwe     <= dram_nWE;
      s_addr    <= dram_addr;
      s_data_in <= dram_data_in;
      p_nras    <= s_nras;
      p_ncas_a  <= s_ncas_a;
      p_ncas_b  <= s_ncas_b;
      p_nwe     <= s_nwe;
      if (ld_row) row_q <= s_addr[ROW_AW-1:0];
      if (ld_col) begin
        col_q  <= s_addr[COL_AW-1:0];
        lane_q <= lane_now;
        nwe_q  <= s_nwe;
      end
      cnt_q   <= cnt_nxt;
      first_q <= first_nxt;
      oe_q    <= oe_nxt;
      nwait_q <= nwait_nxt;
      proto_q <= proto_nxt;
    end
  end

  assign dram_data_oe = oe_q;
  assign dram_nWAIT   = nwait_q;
  assign proto_err    = proto_q;

  dram_bus_target_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_a    (mem_we_a),
    .we_b    (mem_we_b),
    .addr    (mem_addr),
    .wr_dat  (s_data_in),
    .rd_en   (mem_rd_en),
    .rd_lane (mem_rd_lane),
    .rd_dat  (dram_data_out)
  );

endmodule

// File: tb/tb_dram_bus_target.sv
// Purpose: self-checking bench for dram_bus_target, two builds (2 and 0 wait states) on one bus.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: expects nWAIT low for exactly WAIT_STATES cycles per CAS access.
module tb_dram_bus_target;

  logic        clk = 1'b0;
  logic        rst2, rst0;
  logic        dram_nRAS, dram_nCAS_a, dram_nCAS_b, dram_nWE;
  logic [10:0] dram_addr;
  logic [7:0]  dram_data_in;
  logic [7:0]  dout2, dout0;
  logic        oe2, oe0, nwait2, nwait0, perr2, perr0;

  always #5 clk = ~clk;

  dram_bus_target #(.ROW_AW(4), .COL_AW(8), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst2), .dram_nRAS(dram_nRAS), .dram_nCAS_a(dram_nCAS_a),
    .dram_nCAS_b(dram_nCAS_b), .dram_addr(dram_addr), .dram_nWE(dram_nWE),
    .dram_data_in(dram_data_in), .dram_data_out(dout2), .dram_data_oe(oe2),
    .dram_nWAIT(nwait2), .proto_err(perr2));

  dram_bus_target #(.ROW_AW(4), .COL_AW(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .dram_nRAS(dram_nRAS), .dram_nCAS_a(dram_nCAS_a),
    .dram_nCAS_b(dram_nCAS_b), .dram_addr(dram_addr), .dram_nWE(dram_nWE),
    .dram_data_in(dram_data_in), .dram_data_out(dout0), .dram_data_oe(oe0),
    .dram_nWAIT(nwait0), .proto_err(perr0));

  // Reference memory: one byte array per lane, indexed by {row[3:0], col[7:0]}.
  logic [7:0] ref_a [0:4095];
  logic [7:0] ref_b [0:4095];
  bit         known_a [0:4095];
  bit         known_b [0:4095];
  logic [10:0] cur_row;

  int n_chk = 0;
  int n_bad = 0;
  int nw0_low = 0;

  always @(negedge clk) if (nwait0 === 1'b0) nw0_low++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int idx(input logic [10:0] row_addr, input logic [10:0] col_addr);
    return int'({row_addr[3:0], col_addr[7:0]});
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ras_open(input logic [10:0] row_addr);
    dram_addr = row_addr;
    dram_nRAS = 1'b0;
    cur_row   = row_addr;
    cycles(3);
  endtask

  task automatic ras_close();
    dram_nRAS = 1'b1;
    cycles(3);
  endtask

  // One CAS access on both builds; timing and data checked against the model.
  task automatic cas_access(input bit lane, input bit we_n, input logic [10:0] col_addr,
                            input logic [7:0] wdat, input int extra);
    int wl2 = 0, wl0 = 0, f2 = -1, f0 = -1, perr = 0, oew = 0, i;
    logic [7:0] d2 = 8'h00, d0 = 8'h00;
    dram_addr    = col_addr;
    dram_nWE     = we_n;
    dram_data_in = wdat;
    if (lane) dram_nCAS_b = 1'b0; else dram_nCAS_a = 1'b0;
    for (int k = 1; k <= 6 + extra; k++) begin
      @(negedge clk);
      if (nwait2 === 1'b0) wl2++;
      if (nwait0 === 1'b0) wl0++;
      perr += int'(perr2) + int'(perr0);
      if (oe2 === 1'b1 && f2 < 0) begin f2 = k; d2 = dout2; end
      if (oe0 === 1'b1 && f0 < 0) begin f0 = k; d0 = dout0; end
      if (oe2 === 1'b1 || oe0 === 1'b1) oew++;
    end
    i = idx(cur_row, col_addr);
    if (we_n) begin
      chk("rd_lat_ws2", f2, 4);
      chk("rd_lat_ws0", f0, 2);
      if (lane ? known_b[i] : known_a[i]) begin
        chk("rd_dat_ws2", d2, lane ? ref_b[i] : ref_a[i]);
        chk("rd_dat_ws0", d0, lane ? ref_b[i] : ref_a[i]);
        chk("rd_hold_ws2", dout2, lane ? ref_b[i] : ref_a[i]);
      end
    end else begin
      chk("wr_oe_low", oew, 0);
      if (lane) begin ref_b[i] = wdat; known_b[i] = 1'b1; end
      else      begin ref_a[i] = wdat; known_a[i] = 1'b1; end
    end
    chk("nwait_cnt_ws2", wl2, 2);
    chk("nwait_cnt_ws0", wl0, 0);
    dram_nCAS_a = 1'b1;
    dram_nCAS_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      perr += int'(perr2) + int'(perr0);
    end
    chk("oe_off_ws2", oe2, 1'b0);
    chk("oe_off_ws0", oe0, 1'b0);
    chk("proto_quiet", perr, 0);
  endtask

  initial begin
    int p2, p0, oes, n;
    logic [10:0] ra, ca;

    rst2 = 1'b1; rst0 = 1'b1;
    dram_nRAS = 1'b1; dram_nCAS_a = 1'b1; dram_nCAS_b = 1'b1; dram_nWE = 1'b1;
    dram_addr = '0; dram_data_in = '0; cur_row = '0;
    cycles(3);
    chk("rst_nwait", nwait2, 1'b1);
    chk("rst_oe", oe2, 1'b0);
    chk("rst_dout", dout2, 8'h00);
    chk("rst_proto", perr2, 1'b0);
    chk("rst_nwait0", nwait0, 1'b1);
    chk("rst_oe0", oe0, 1'b0);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_proto0", perr0, 1'b0);
    rst2 = 1'b0; rst0 = 1'b0;
    cycles(2);

    // Write then read, row 3 col 0x12.
    ras_open(11'h003);
    cas_access(1'b0, 1'b0, 11'h012, 8'hA5, 0);
    cas_access(1'b0, 1'b1, 11'h012, 8'h00, 1);
    ras_close();

    // Byte lanes at row 1 col 0x40.
    ras_open(11'h001);
    cas_access(1'b0, 1'b0, 11'h040, 8'h11, 0);
    cas_access(1'b1, 1'b0, 11'h040, 8'h22, 0);
    cas_access(1'b0, 1'b1, 11'h040, 8'h00, 0);
    cas_access(1'b1, 1'b1, 11'h040, 8'h00, 0);
    ras_close();

    // Page mode: preload then four reads under one RAS, upper address bits toggling.
    ras_open(11'h005);
    for (int c = 0; c < 4; c++) cas_access(1'b0, 1'b0, 11'(c), 8'(8'h10 + c), 0);
    ras_close();
    ras_open(11'h005);
    for (int c = 0; c < 4; c++) cas_access(1'b0, 1'b1, 11'(c) | 11'h700, 8'h00, 0);
    ras_close();

    // Simultaneous CAS: pulse, no drive, no write.
    ras_open(11'h001);
    dram_addr = 11'h040; dram_nWE = 1'b0; dram_data_in = 8'hEE;
    dram_nCAS_a = 1'b0; dram_nCAS_b = 1'b0;
    p2 = 0; p0 = 0; oes = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p2 += int'(perr2); p0 += int'(perr0);
      if (oe2 === 1'b1 || oe0 === 1'b1) oes++;
    end
    chk("dual_cas_proto", p2, 1);
    chk("dual_cas_proto0", p0, 1);
    chk("dual_cas_oe", oes, 0);
    dram_nCAS_a = 1'b1; dram_nCAS_b = 1'b1;
    cycles(3);
    cas_access(1'b0, 1'b1, 11'h040, 8'h00, 0);
    cas_access(1'b1, 1'b1, 11'h040, 8'h00, 0);
    ras_close();

    // Abort: nRAS rises while the write of 0x5A waits.
    ras_open(11'h002);
    cas_access(1'b0, 1'b0, 11'h033, 8'h00, 0);
    dram_addr = 11'h033; dram_nWE = 1'b0; dram_data_in = 8'h5A; dram_nCAS_a = 1'b0;
    @(negedge clk);
    dram_nRAS = 1'b1;
    p2 = 0; p0 = 0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      p2 += int'(perr2); p0 += int'(perr0);
      if (k == 2) chk("abort_in_wait", nwait2, 1'b0);
    end
    chk("abort_nwait", nwait2, 1'b1);
    chk("abort_oe", oe2, 1'b0);
    chk("abort_proto", p2, 1);
    chk("abort_proto0", p0, 1);
    dram_nCAS_a = 1'b1;
    cycles(3);
    ras_open(11'h002);
    cas_access(1'b0, 1'b1, 11'h033, 8'h00, 0);
    ras_close();

    // Reset of the zero-wait build during the ACCESS of a read.
    ras_open(11'h003);
    dram_addr = 11'h012; dram_nWE = 1'b1; dram_nCAS_a = 1'b0;
    cycles(2);
    chk("ws0_pre_rst_oe", oe0, 1'b1);
    chk("ws0_pre_rst_dat", dout0, ref_a[idx(11'h003, 11'h012)]);
    rst0 = 1'b1;
    @(negedge clk);
    chk("ws0_rst_oe", oe0, 1'b0);
    chk("ws0_rst_dout", dout0, 8'h00);
    chk("ws0_rst_nwait", nwait0, 1'b1);
    rst0 = 1'b0;
    cycles(4);
    dram_nCAS_a = 1'b1;
    cycles(3);
    ras_close();
    ras_open(11'h003);
    cas_access(1'b0, 1'b1, 11'h012, 8'h00, 0);
    ras_close();

    // Random pages over a small aliased address pool.
    for (int pg = 0; pg < 25; pg++) begin
      ra = 11'($urandom) & 11'h7F3;
      ras_open(ra);
      n = $urandom_range(1, 4);
      for (int a = 0; a < n; a++) begin
        ca = 11'($urandom) & 11'h707;
        cas_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ca,
                   8'($urandom), $urandom_range(0, 2));
      end
      ras_close();
    end

    chk("ws0_nwait_never_low", nw0_low, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
